// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - op codes, size codes, FSM states and op helpers for the memory stage
package mem_access_ctrl_pkg;

  // Execute-stage op codes for memory instructions
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  // Bus transfer size codes
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic is_load(input logic [7:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
           (op == EXE_LHU_OP) || (op == EXE_LW_OP);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  function automatic logic is_mem_op(input logic [7:0] op);
    return is_load(op) || is_store(op);
  endfunction

  // Halfword accesses need bit 0 clear, word accesses need bits 1:0 clear
  function automatic logic misaligned(input logic [7:0] op, input logic [1:0] addr_lo);
    case (op)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return addr_lo[0];
      EXE_LW_OP, EXE_SW_OP:             return |addr_lo;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// rtl/mem_lane_fmt.sv - store lane replication/strobes and load lane extraction/extension
module mem_lane_fmt
  import mem_access_ctrl_pkg::*;
(
  input  logic [7:0]  st_op,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  input  logic [7:0]  ld_op,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_data,
  output logic [1:0]  size,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ld_ext
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: transfer size, replicated data and byte enables for the issuing op
  always_comb begin
    size  = SIZE_W;
    wstrb = 4'b0000;
    wdata = 32'h0;
    case (st_op)
      EXE_LB_OP, EXE_LBU_OP: size = SIZE_B;
      EXE_LH_OP, EXE_LHU_OP: size = SIZE_H;
      EXE_SB_OP: begin
        size  = SIZE_B;
        wdata = {4{st_data[7:0]}};
        wstrb = 4'b0001 << st_addr_lo;
      end
      EXE_SH_OP: begin
        size  = SIZE_H;
        wdata = {2{st_data[15:0]}};
        wstrb = st_addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      EXE_SW_OP: begin
        wdata = st_data;
        wstrb = 4'b1111;
      end
      default: ;
    endcase
  end

  // Load side: pick the addressed lane from the response word and extend it
  always_comb begin
    ld_byte = ld_data[7:0];
    case (ld_addr_lo)
      2'd1:    ld_byte = ld_data[15:8];
      2'd2:    ld_byte = ld_data[23:16];
      2'd3:    ld_byte = ld_data[31:24];
      default: ld_byte = ld_data[7:0];
    endcase
    ld_half = ld_addr_lo[1] ? ld_data[31:16] : ld_data[15:0];
    case (ld_op)
      EXE_LB_OP:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      EXE_LBU_OP: ld_ext = {24'h0, ld_byte};
      EXE_LH_OP:  ld_ext = {{16{ld_half[15]}}, ld_half};
      EXE_LHU_OP: ld_ext = {16'h0, ld_half};
      EXE_LW_OP:  ld_ext = ld_data;
      default:    ld_ext = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - memory-stage load/store controller on a split-transaction SRAM bus
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [7:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic              flush,
  input  logic              pipe_stall,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [DATA_W-1:0] load_result,
  output logic              done,
  output logic              stall,
  output logic              adel,
  output logic              ades,
  output logic [ADDR_W-1:0] bad_vaddr
);

  state_t      state;
  logic [7:0]  op_q;
  logic        in_idle;
  logic        fault;
  logic        accept;
  logic [1:0]  fmt_size;
  logic [3:0]  fmt_wstrb;
  logic [31:0] fmt_wdata;
  logic [31:0] fmt_ld_ext;

  assign in_idle = (state == ST_IDLE);
  assign fault   = misaligned(op, addr[1:0]);
  assign accept  = in_idle && valid && is_mem_op(op) && !fault && !flush;

  // Address errors are reported only for the instruction sitting in M while idle;
  // outputs are forced low while reset is asserted.
  assign adel      = rst && in_idle && valid && !flush && fault && is_load(op);
  assign ades      = rst && in_idle && valid && !flush && fault && is_store(op);
  assign bad_vaddr = (adel || ades) ? addr : '0;

  // Hold the pipeline while a request is in flight, on the accept cycle, and while a
  // squashed response is still outstanding and another memory op is waiting to issue.
  assign stall = rst && ((state == ST_REQ) || (state == ST_WAIT) || accept ||
                         ((state == ST_DRAIN) && valid && is_mem_op(op)));

  // Store formatting uses the live op/address; load extraction uses the latched request
  mem_lane_fmt u_lane_fmt (
    .st_op      (op),
    .st_addr_lo (addr[1:0]),
    .st_data    (store_data),
    .ld_op      (op_q),
    .ld_addr_lo (data_addr[1:0]),
    .ld_data    (data_rdata),
    .size       (fmt_size),
    .wstrb      (fmt_wstrb),
    .wdata      (fmt_wdata),
    .ld_ext     (fmt_ld_ext)
  );

  // Transaction FSM: accept, request handshake, response wait, squash drain, completion hold
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      op_q        <= 8'h0;
      data_req    <= 1'b0;
      data_wr     <= 1'b0;
      data_size   <= 2'd0;
      data_addr   <= '0;
      data_wdata  <= '0;
      data_wstrb  <= 4'b0000;
      load_result <= '0;
      done        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q       <= op;
            data_addr  <= addr;
            data_size  <= fmt_size;
            data_wstrb <= fmt_wstrb;
            data_wdata <= fmt_wdata;
            data_wr    <= is_store(op);
            data_req   <= 1'b1;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (data_addr_ok) begin
            // An accepted request will produce a response even if squashed now
            data_req <= 1'b0;
            state    <= flush ? ST_DRAIN : ST_WAIT;
          end else if (flush) begin
            data_req <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (flush) begin
            state <= data_data_ok ? ST_IDLE : ST_DRAIN;
          end else if (data_data_ok) begin
            if (is_load(op_q)) load_result <= fmt_ld_ext;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DRAIN: begin
          if (data_data_ok) state <= ST_IDLE;
        end
        ST_DONE: begin
          if (flush || !pipe_stall) begin
            done  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [7:0]  op;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        flush;
  logic        pipe_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] load_result;
  logic        done;
  logic        stall;
  logic        adel;
  logic        ades;
  logic [31:0] bad_vaddr;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid        (valid),
    .op           (op),
    .addr         (addr),
    .store_data   (store_data),
    .flush        (flush),
    .pipe_stall   (pipe_stall),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_wstrb   (data_wstrb),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .load_result  (load_result),
    .done         (done),
    .stall        (stall),
    .adel         (adel),
    .ades         (ades),
    .bad_vaddr    (bad_vaddr)
  );

  // Reference model: access width in bytes, 0 for non-memory ops
  function automatic int ref_bytes(input logic [7:0] o);
    if (o == EXE_LB_OP || o == EXE_LBU_OP || o == EXE_SB_OP) return 1;
    if (o == EXE_LH_OP || o == EXE_LHU_OP || o == EXE_SH_OP) return 2;
    if (o == EXE_LW_OP || o == EXE_SW_OP) return 4;
    return 0;
  endfunction

  function automatic logic ref_is_store(input logic [7:0] o);
    return (o == EXE_SB_OP || o == EXE_SH_OP || o == EXE_SW_OP);
  endfunction

  function automatic logic ref_signed(input logic [7:0] o);
    return (o == EXE_LB_OP || o == EXE_LH_OP);
  endfunction

  function automatic logic [1:0] ref_size(input logic [7:0] o);
    int n = ref_bytes(o);
    return (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic ref_fault(input logic [7:0] o, input logic [31:0] a);
    int n = ref_bytes(o);
    return (n > 1) && ((a % n) != 0);
  endfunction

  function automatic logic [3:0] ref_wstrb(input logic [7:0] o, input logic [31:0] a);
    int n = ref_bytes(o);
    if (!ref_is_store(o)) return 4'b0000;
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [7:0] o, input logic [31:0] sd);
    int n = ref_bytes(o);
    if (n == 1) return (sd & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [7:0] o, input logic [31:0] a, input logic [31:0] rd);
    int n = ref_bytes(o);
    logic [31:0] mask, v;
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
    v = (rd >> (8 * (a % 4))) & mask;
    if (ref_signed(o) && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one instruction from IDLE to retirement and checks every cycle against the model.
  // Starts and ends just after a rising edge.
  task automatic run_access(input logic [7:0] o, input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] rd, input int aok, input int dok, input int ps);
    int          n;
    logic        st;
    logic [31:0] lr;
    n  = ref_bytes(o);
    st = ref_is_store(o);
    lr = ref_load(o, a, rd);
    valid = 1'b1; op = o; addr = a; store_data = sd; flush = 1'b0; pipe_stall = 1'b0;
    @(negedge clk);
    if (n == 0) begin
      total_cnt++; if (stall !== 1'b0 || adel !== 1'b0 || ades !== 1'b0) $display("FAIL nonmem_idle: stall=%0b adel=%0b ades=%0b required 0", stall, adel, ades); else pass_cnt++;
      tick(); valid = 1'b0;
      @(negedge clk);
      total_cnt++; if (data_req !== 1'b0 || done !== 1'b0) $display("FAIL nonmem_req: data_req=%0b done=%0b required 0", data_req, done); else pass_cnt++;
      tick();
      return;
    end
    if (ref_fault(o, a)) begin
      total_cnt++; if (adel !== !st || ades !== st) $display("FAIL fault_flag op=%h addr=%h: adel=%0b ades=%0b required %0b %0b", o, a, adel, ades, !st, st); else pass_cnt++;
      total_cnt++; if (bad_vaddr !== a) $display("FAIL bad_vaddr: %h required %h", bad_vaddr, a); else pass_cnt++;
      total_cnt++; if (stall !== 1'b0) $display("FAIL fault_stall: %0b required 0", stall); else pass_cnt++;
      tick(); valid = 1'b0;
      @(negedge clk);
      total_cnt++; if (data_req !== 1'b0 || adel !== 1'b0 || ades !== 1'b0) $display("FAIL fault_after: data_req=%0b adel=%0b ades=%0b required 0", data_req, adel, ades); else pass_cnt++;
      tick();
      return;
    end
    total_cnt++; if (stall !== 1'b1 || data_req !== 1'b0) $display("FAIL accept: stall=%0b data_req=%0b required 1 0", stall, data_req); else pass_cnt++;
    tick();
    for (int i = 0; i <= aok; i++) begin
      data_addr_ok = (i == aok);
      @(negedge clk);
      total_cnt++; if (data_req !== 1'b1 || stall !== 1'b1) $display("FAIL req_phase %0d: data_req=%0b stall=%0b required 1 1", i, data_req, stall); else pass_cnt++;
      total_cnt++; if (data_addr !== a || data_size !== ref_size(o) || data_wr !== st) $display("FAIL req_fields: addr=%h size=%0d wr=%0b required %h %0d %0b", data_addr, data_size, data_wr, a, ref_size(o), st); else pass_cnt++;
      total_cnt++; if (data_wstrb !== ref_wstrb(o, a) || (st && data_wdata !== ref_wdata(o, sd))) $display("FAIL req_lanes: wstrb=%b wdata=%h required %b %h", data_wstrb, data_wdata, ref_wstrb(o, a), ref_wdata(o, sd)); else pass_cnt++;
      tick();
    end
    data_addr_ok = 1'b0;
    for (int i = 0; i <= dok; i++) begin
      data_data_ok = (i == dok);
      data_rdata   = (i == dok) ? rd : $urandom;
      @(negedge clk);
      total_cnt++; if (data_req !== 1'b0 || stall !== 1'b1 || done !== 1'b0) $display("FAIL wait_phase %0d: data_req=%0b stall=%0b done=%0b required 0 1 0", i, data_req, stall, done); else pass_cnt++;
      tick();
    end
    data_data_ok = 1'b0;
    data_rdata   = $urandom;
    for (int k = 0; k <= ps; k++) begin
      pipe_stall = (k < ps);
      @(negedge clk);
      total_cnt++; if (done !== 1'b1 || stall !== 1'b0 || data_req !== 1'b0) $display("FAIL done_phase %0d: done=%0b stall=%0b data_req=%0b required 1 0 0", k, done, stall, data_req); else pass_cnt++;
      if (!st) begin
        total_cnt++; if (load_result !== lr) $display("FAIL load_result op=%h addr=%h: %h required %h", o, a, load_result, lr); else pass_cnt++;
      end
      tick();
    end
    pipe_stall = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (done !== 1'b0 || data_req !== 1'b0) $display("FAIL retire: done=%0b data_req=%0b required 0 0", done, data_req); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; valid = 1'b0; op = 8'h0; addr = 32'h0; store_data = 32'h0; flush = 1'b0;
    pipe_stall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    repeat (3) tick();
    @(negedge clk);
    total_cnt++; if (data_req !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || adel !== 1'b0 || ades !== 1'b0) $display("FAIL reset_ctrl: req=%0b done=%0b stall=%0b adel=%0b ades=%0b required 0", data_req, done, stall, adel, ades); else pass_cnt++;
    total_cnt++; if (load_result !== 32'h0 || data_addr !== 32'h0 || data_wstrb !== 4'h0 || data_wdata !== 32'h0 || bad_vaddr !== 32'h0 || data_wr !== 1'b0 || data_size !== 2'd0) $display("FAIL reset_data: lr=%h addr=%h wstrb=%b wdata=%h bad=%h required 0", load_result, data_addr, data_wstrb, data_wdata, bad_vaddr); else pass_cnt++;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_load_byte();
    run_access(EXE_LB_OP,  32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0, 0);
    run_access(EXE_LBU_OP, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0, 0);
  endtask

  task automatic test_store_half();
    run_access(EXE_SH_OP, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0, 0, 1, 0);
    run_access(EXE_SB_OP, 32'h0000_2001, 32'h1234_56A5, 32'h0, 1, 0, 0);
  endtask

  task automatic test_misaligned();
    run_access(EXE_LW_OP,  32'h0000_3001, 32'h0, 32'h0, 0, 0, 0);
    run_access(EXE_SW_OP,  32'h0000_3002, 32'h0, 32'h0, 0, 0, 0);
    run_access(EXE_LHU_OP, 32'h0000_3003, 32'h0, 32'h0, 0, 0, 0);
  endtask

  task automatic test_handshake_delay();
    run_access(EXE_LW_OP, 32'h0000_6000, 32'h0, 32'hCAFE_F00D, 3, 2, 0);
  endtask

  task automatic test_pipe_stall_done();
    run_access(EXE_LH_OP, 32'h0000_7002, 32'h0, 32'h9ABC_0011, 0, 0, 2);
  endtask

  task automatic test_flush_req();
    valid = 1'b1; op = EXE_SB_OP; addr = 32'h0000_8000; store_data = 32'h55;
    tick();
    flush = 1'b1;
    @(negedge clk);
    total_cnt++; if (data_req !== 1'b1) $display("FAIL flush_req_before: data_req=%0b required 1", data_req); else pass_cnt++;
    tick();
    flush = 1'b0; valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (data_req !== 1'b0 || stall !== 1'b0) $display("FAIL flush_req_after: data_req=%0b stall=%0b required 0 0", data_req, stall); else pass_cnt++;
    tick();
  endtask

  task automatic test_flush_drain();
    valid = 1'b1; op = EXE_LB_OP; addr = 32'h0000_1000; store_data = 32'h0;
    tick();
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    total_cnt++; if (stall !== 1'b1 || data_req !== 1'b0) $display("FAIL flush_wait: stall=%0b data_req=%0b required 1 0", stall, data_req); else pass_cnt++;
    tick();
    flush = 1'b0; op = EXE_LW_OP; addr = 32'h0000_4000; valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total_cnt++; if (stall !== 1'b1 || data_req !== 1'b0 || done !== 1'b0) $display("FAIL drain_hold %0d: stall=%0b data_req=%0b done=%0b required 1 0 0", i, stall, data_req, done); else pass_cnt++;
      tick();
    end
    data_data_ok = 1'b1; data_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    total_cnt++; if (stall !== 1'b1 || data_req !== 1'b0 || done !== 1'b0) $display("FAIL drain_resp: stall=%0b data_req=%0b done=%0b required 1 0 0", stall, data_req, done); else pass_cnt++;
    tick();
    data_data_ok = 1'b0;
    run_access(EXE_LW_OP, 32'h0000_4000, 32'h0, 32'h1234_5678, 1, 1, 0);
  endtask

  task automatic test_reset_mid_req();
    valid = 1'b1; op = EXE_LW_OP; addr = 32'h0000_5000;
    tick();
    @(negedge clk);
    total_cnt++; if (data_req !== 1'b1) $display("FAIL rst_req_before: data_req=%0b required 1", data_req); else pass_cnt++;
    tick();
    rst = 1'b0;
    tick();
    valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (data_req !== 1'b0 || stall !== 1'b0 || done !== 1'b0) $display("FAIL rst_req_after: data_req=%0b stall=%0b done=%0b required 0", data_req, stall, done); else pass_cnt++;
    tick();
    rst = 1'b1;
    tick();
    run_access(EXE_SW_OP, 32'h0000_5004, 32'h0BAD_CAFE, 32'h0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [7:0] ops [10];
    ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, 8'h00, 8'h25};
    for (int i = 0; i < 60; i++) begin
      logic [7:0]  o;
      logic [31:0] a, sd, rd;
      o  = ops[$urandom_range(0, 9)];
      a  = $urandom;
      sd = $urandom;
      rd = $urandom;
      run_access(o, a, sd, rd, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_handshake_delay();
    test_pipe_stall_done();
    test_flush_req();
    test_flush_drain();
    test_reset_mid_req();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
